// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush controller for the 5-stage pipeline: load-use, MEM-resolved branches, dmem waits with timeout trap.
// Define PIPE_HAZARD_CTRL_PERF_EN to build the stall_cycles / flush_events performance counters.
module pipe_hazard_ctrl #(
  parameter int MAX_WAIT = 16
) (
  input  logic        clk,
  input  logic        arst_n,
  input  logic [4:0]  rs1_IF_ID,
  input  logic [4:0]  rs2_IF_ID,
  input  logic        memread_ID_EX,
  input  logic [4:0]  inst2_ID_EX,
  input  logic        memread_EX_MEM,
  input  logic        memwrite_EX_MEM,
  input  logic        membranch_EX_MEM,
  input  logic        zero_EX_MEM,
  input  logic        dmem_ready,
  output logic        en_pc,
  output logic        en_IF_ID,
  output logic        en_ID_EX,
  output logic        en_EX_MEM,
  output logic        en_MEM_WB,
  output logic        flush_IF_ID,
  output logic        flush_ID_EX,
  output logic        flush_EX_MEM,
  output logic        flush_MEM_WB,
  output logic        pc_sel,
  output logic        err,
  output logic [31:0] stall_cycles,
  output logic [31:0] flush_events
);

  localparam int CNT_W = $clog2(MAX_WAIT + 1);

  typedef enum logic [1:0] {RUN, WAIT, HALT} state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] wait_cnt_q, wait_cnt_d;
  logic             err_q, err_d;

  logic mem_acc, br, lu;
  logic do_stall, do_br, do_lu, halted;

  assign mem_acc = memread_EX_MEM | memwrite_EX_MEM;
  assign br      = membranch_EX_MEM & zero_EX_MEM;
  assign lu      = memread_ID_EX && (inst2_ID_EX != 5'd0) &&
                   ((inst2_ID_EX == rs1_IF_ID) || (inst2_ID_EX == rs2_IF_ID));

  always_comb begin
    state_d    = state_q;
    wait_cnt_d = wait_cnt_q;
    err_d      = err_q;
    do_stall   = 1'b0;
    do_br      = 1'b0;
    do_lu      = 1'b0;
    halted     = 1'b0;
    case (state_q)
      RUN: begin
        if (mem_acc && !dmem_ready) begin
          do_stall   = 1'b1;
          state_d    = WAIT;
          wait_cnt_d = CNT_W'(1);
        end else if (br) begin
          do_br = 1'b1;
        end else if (lu) begin
          do_lu = 1'b1;
        end
      end
      WAIT: begin
        if (dmem_ready) begin
          state_d    = RUN;
          wait_cnt_d = '0;
          if (br) begin
            do_br = 1'b1;
          end else if (lu) begin
            do_lu = 1'b1;
          end
        end else begin
          do_stall = 1'b1;
          if (wait_cnt_q == CNT_W'(MAX_WAIT)) begin
            state_d = HALT;
            err_d   = 1'b1;
          end else begin
            wait_cnt_d = wait_cnt_q + CNT_W'(1);
          end
        end
      end
      HALT: begin
        halted = 1'b1;
        err_d  = 1'b1;
      end
      default: begin
        state_d    = RUN;
        wait_cnt_d = '0;
      end
    endcase
  end

  // Enables and bubbles are forced low for as long as reset is held.
  assign en_pc        = arst_n & ~halted & ~do_stall & ~do_lu;
  assign en_IF_ID     = arst_n & ~halted & ~do_stall & ~do_lu;
  assign en_ID_EX     = arst_n & ~halted & ~do_stall;
  assign en_EX_MEM    = arst_n & ~halted & ~do_stall;
  assign en_MEM_WB    = arst_n & ~halted;
  assign flush_IF_ID  = arst_n & do_br;
  assign flush_ID_EX  = arst_n & (do_br | do_lu);
  assign flush_EX_MEM = arst_n & do_br;
  assign flush_MEM_WB = arst_n & do_stall;
  assign pc_sel       = arst_n & do_br;
  assign err          = err_q;

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      state_q    <= RUN;
      wait_cnt_q <= '0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
      err_q      <= err_d;
    end
  end

`ifdef PIPE_HAZARD_CTRL_PERF_EN
  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

  logic [31:0] stall_cnt_q, flush_cnt_q;

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      if (!halted && (do_stall || do_lu)) stall_cnt_q <= sat_inc(stall_cnt_q);
      if (do_br) flush_cnt_q <= sat_inc(flush_cnt_q);
    end
  end

  assign stall_cycles = stall_cnt_q;
  assign flush_events = flush_cnt_q;
`else
  assign stall_cycles = 32'd0;
  assign flush_events = 32'd0;
`endif

endmodule
